// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ sources.
// One-cycle registered output (D/En/Wr_addr); Hold or reset forces all Req_ready low.
module regfile_wr_arbiter #(
  parameter int N_REQ    = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic [N_REQ-1:0]      Req_valid,
  input  logic [5*N_REQ-1:0]    Req_addr,
  input  logic [32*N_REQ-1:0]   Req_data,
  output logic [N_REQ-1:0]      Req_ready,
  input  logic                  Hold,
  output logic [31:0]           D,
  output logic [31:0]           En,
  output logic                  Wr_valid,
  output logic [4:0]            Wr_addr
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          wr_valid_q, wr_valid_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   d_q, d_d;
  logic [31:0]   en_q, en_d;

  logic             found;
  logic [N_REQ-1:0] gnt_oh;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    gnt_next;
  logic             xfer;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;

  // Scan priority slots ptr, ptr+1, ... and take the first valid requester.
  always_comb begin
    found   = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && Req_valid[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + N_REQ))) begin
          found     = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_idx   = PW'(i);
        end
      end
    end
  end

  assign Req_ready = (Clrn && !Hold) ? gnt_oh : '0;
  assign xfer      = |Req_ready;
  assign gnt_next  = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_addr = Req_addr[5*i +: 5];
        sel_data = Req_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    wr_valid_d = xfer;
    wr_addr_d  = wr_addr_q;
    d_d        = d_q;
    en_d       = '0;
    if (xfer) begin
      ptr_d     = gnt_next;
      wr_addr_d = sel_addr;
      d_d       = sel_data;
      // r0 writes still show as valid on Wr_valid but never reach the array.
      if (!(ZERO_REG && (sel_addr == 5'd0))) begin
        en_d = 32'd1 << sel_addr;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      ptr_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      d_q        <= '0;
      en_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      d_q        <= d_d;
      en_q       <= en_d;
    end
  end

  assign D        = d_q;
  assign En       = en_q;
  assign Wr_valid = wr_valid_q;
  assign Wr_addr  = wr_addr_q;

endmodule
